seg7_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_decode.sv | 25 ++
 rtl/seg7_reader.sv | 114 +++++++++++
 tb/tb_seg7_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns (g..a, active-high), special codes and reader FSM states.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR = 4'hE;
  typedef enum logic [0:0] {SYNC = 1'b0, COLLECT = 1'b1} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-high segment pattern to 4-bit code, err set for unrecognised patterns.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);
  always_comb
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_ERR;
    endcase
  assign err = code == CODE_ERR;
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers multiplexed 7-segment frames with debounce and valid/ready output.
// Define SEG7_READER_OVF_CNT_EN to count dropped frames on ovf_cnt (tied to zero otherwise).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        nseg,
  input  logic [NDIG-1:0]   nan,
  output logic [4*NDIG-1:0] out_digits,
  output logic [NDIG-1:0]   out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              desync,
  output logic [7:0]        ovf_cnt
);
  localparam int IW = $clog2(NDIG);
  logic [6:0] nseg_m, nseg_s, seg;
  logic [NDIG-1:0] nan_m, nan_s, an;
  logic active, same, armed, cap;
  logic [IW-1:0] idx;
  logic [IW+7:0] cur, prev;
  logic [7:0] cnt;
  logic [8:0] cnt_inc;
  logic [3:0] code, cap_code;
  logic err, cap_q, cap_err;
  logic [IW-1:0] cap_idx, exp_idx;
  state_t state;
  logic [4*NDIG-1:0] slot_digits, frame_digits;
  logic [NDIG-1:0] slot_err, frame_err;
  logic hit, start, abort, done, free;
  assign seg = ~nseg_s;
  assign an = ~nan_s;
  assign active = $onehot(an);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) if (an[i]) idx = IW'(i);
  end
  assign cur = {active, idx, seg};
  assign same = cur == prev;
  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign cap = active && same && armed && cnt_inc == 9'(STABLE_CYC);
  seg7_decode u_dec (.seg(seg), .code(code), .err(err));
  // armed re-arms on any change so a long dwell captures only once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {nseg_m, nseg_s} <= '0;
      {nan_m, nan_s} <= '0;
      prev <= '0;
      cnt <= '0;
      armed <= 1'b1;
      cap_q <= 1'b0;
      cap_idx <= '0;
      cap_code <= '0;
      cap_err <= 1'b0;
    end else begin
      nseg_m <= nseg;
      nseg_s <= nseg_m;
      nan_m <= nan;
      nan_s <= nan_m;
      prev <= cur;
      cnt <= active && same ? (cnt_inc[8] ? cnt : cnt_inc[7:0]) : '0;
      armed <= !same || (armed && !cap);
      cap_q <= cap;
      cap_idx <= idx;
      cap_code <= code;
      cap_err <= err;
    end
  assign hit = cap_q && state == COLLECT && cap_idx == exp_idx;
  assign abort = cap_q && state == COLLECT && cap_idx != exp_idx;
  assign start = cap_q && cap_idx == '0;
  assign done = hit && exp_idx == IW'(NDIG - 1);
  assign free = !out_valid || out_ready;
  always_comb begin
    frame_digits = slot_digits;
    frame_err = slot_err;
    frame_digits[4*cap_idx +: 4] = cap_code;
    frame_err[cap_idx] = cap_err;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SYNC;
      exp_idx <= '0;
      slot_digits <= '0;
      slot_err <= '0;
      desync <= 1'b0;
      out_digits <= '0;
      out_err <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= done ? SYNC : (start || hit) ? COLLECT : abort ? SYNC : state;
      exp_idx <= start ? IW'(1) : hit ? exp_idx + 1'b1 : exp_idx;
      if (start || hit) begin
        slot_digits <= frame_digits;
        slot_err <= frame_err;
      end
      desync <= abort;
      if (done && free) begin
        out_digits <= frame_digits;
        out_err <= frame_err;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef SEG7_READER_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_cnt <= '0;
    else if (done && !free && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
`else
  assign ovf_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed scans checked every cycle against a frame-level model of the reader.
module tb_seg7_reader;
  localparam int N = 4, S = 4, HL = S + 4;
  localparam logic [6:0] P [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [6:0] nseg = '1;
  logic [N-1:0] nan = '1;
  logic [4*N-1:0] out_digits;
  logic [N-1:0] out_err;
  logic out_valid, desync;
  logic [7:0] ovf_cnt;
  int checks = 0, failures = 0;
  seg7_reader #(.NDIG(N), .STABLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .nseg(nseg), .nan(nan), .out_digits(out_digits), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .desync(desync), .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [4:0] dec(input logic [6:0] s);
    dec = (s == 7'h00) ? 5'h0F : 5'h1E;
    for (int d = 0; d < 10; d++) if (P[d] == s) dec = {1'b0, 4'(d)};
  endfunction
  // model: a capture happens when a synchronized sample has repeated exactly S times
  logic [N+6:0] hist [HL];
  logic [4:0] m_frame [$];
  logic p_cap, m_valid, m_desync, done;
  int p_idx;
  logic [4:0] p_val;
  logic [4*N-1:0] m_digits;
  logic [N-1:0] m_err;
  logic [7:0] m_ovf;
  logic [N+6:0] v;
  always @(posedge clk or posedge rst)
    if (rst) begin
      foreach (hist[i]) hist[i] = '0;
      m_frame.delete();
      p_cap = 0; m_valid = 0; m_desync = 0; m_digits = '0; m_err = '0; m_ovf = '0;
    end else begin
      done = 0;
      m_desync = 0;
      if (p_cap) begin
        if (m_frame.size() > 0 && p_idx != m_frame.size()) begin
          m_desync = 1;
          m_frame.delete();
        end
        if (p_idx == m_frame.size()) m_frame.push_back(p_val);
        done = m_frame.size() == N;
      end
      if (done && (!m_valid || out_ready)) begin
        for (int j = 0; j < N; j++) begin
          m_digits[4*j +: 4] = m_frame[j][3:0];
          m_err[j] = m_frame[j][4];
        end
        m_valid = 1;
      end else begin
`ifdef SEG7_READER_OVF_CNT_EN
        if (done && m_ovf != 8'hFF) m_ovf = m_ovf + 1;
`endif
        if (out_ready) m_valid = 0;
      end
      if (done) m_frame.delete();
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {nan, nseg};
      v = hist[2];
      p_cap = $onehot(~v[N+6:7]) && hist[3+S] != v;
      for (int j = 3; j <= 2 + S; j++) if (hist[j] != v) p_cap = 0;
      p_idx = 0;
      for (int j = 0; j < N; j++) if (!v[7+j]) p_idx = j;
      p_val = dec(~v[6:0]);
    end
  int nframes = 0, vcyc = 0, ndes = 0;
  logic prev_v = 0;
  logic [4*N-1:0] last_frame = '0;
  logic [N-1:0] last_err = '0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("desync", 32'(desync), 32'(m_desync));
      chk("digits", 32'(out_digits), 32'(m_digits));
      chk("err", 32'(out_err), 32'(m_err));
      chk("ovf", 32'(ovf_cnt), 32'(m_ovf));
    end
    if (out_valid && !prev_v) begin
      nframes++;
      last_frame = out_digits;
      last_err = out_err;
    end
    if (out_valid) vcyc++;
    if (desync) ndes++;
    prev_v = out_valid;
  end
  task automatic drive(input logic [6:0] s, input int d, input int cyc);
    nseg = ~s;
    nan = ~4'(1 << d);
    repeat (cyc) @(negedge clk);
  endtask
  task automatic idle(input int cyc);
    nseg = '1;
    nan = '1;
    repeat (cyc) @(negedge clk);
  endtask
  task automatic scan(input logic [27:0] pats, input int hold);
    for (int d = 0; d < 4; d++) drive(pats[7*d +: 7], d, hold);
    idle(8);
  endtask
  int f0, v0, d0;
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_digits", 32'(out_digits), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    f0 = nframes; v0 = vcyc;
    scan({P[4], P[3], P[2], P[1]}, 10);
    chk("t1_frames", nframes - f0, 1);
    chk("t1_vcyc", vcyc - v0, 1);
    chk("t1_frame", 32'(last_frame), 32'h4321);
    chk("t1_err", 32'(last_err), 0);
    chk("t1_model", 32'(m_digits), 32'h4321);
    scan({P[8], 7'h01, P[8], P[8]}, 10);
    chk("t2_frame", 32'(last_frame), 32'h8E88);
    chk("t2_err", 32'(last_err), 32'b0100);
    scan({P[8], P[8], 7'h00, P[8]}, 10);
    chk("t3_frame", 32'(last_frame), 32'h88F8);
    chk("t3_err", 32'(last_err), 0);
    f0 = nframes;
    scan({P[7], P[7], P[7], P[7]}, S - 1);
    chk("t4_nocap", nframes - f0, 0);
    f0 = nframes; d0 = ndes;
    drive(P[1], 0, 10); drive(P[2], 1, 10); drive(P[3], 3, 10); idle(8);
    chk("t5_desync", ndes - d0, 1);
    chk("t5_noframe", nframes - f0, 0);
    scan({P[8], P[7], P[6], P[5]}, 10);
    chk("t5_frame", 32'(last_frame), 32'h8765);
    chk("t5_frames", nframes - f0, 1);
    out_ready = 0;
    f0 = nframes;
    scan({P[4], P[3], P[2], P[1]}, 10);
    scan({P[2], P[1], P[0], P[9]}, 10);
    chk("t6_held_valid", 32'(out_valid), 1);
    chk("t6_held_frame", 32'(out_digits), 32'h4321);
`ifdef SEG7_READER_OVF_CNT_EN
    chk("t6_ovf", 32'(ovf_cnt), 1);
`else
    chk("t6_ovf", 32'(ovf_cnt), 0);
`endif
    out_ready = 1;
    @(negedge clk);
    chk("t6_accepted", 32'(out_valid), 0);
    chk("t6_frames", nframes - f0, 1);
    out_ready = 0;
    scan({P[4], P[3], P[2], P[1]}, 10);
    drive(P[5], 0, 10); drive(P[6], 1, 10);
    #2 rst = 1;
    #1;
    chk("t7_async_valid", 32'(out_valid), 0);
    chk("t7_async_digits", 32'(out_digits), 0);
    chk("t7_async_ovf", 32'(ovf_cnt), 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    f0 = nframes;
    scan({P[1], P[4], P[1], P[3]}, 10);
    chk("t7_frames", nframes - f0, 1);
    chk("t7_frame", 32'(last_frame), 32'h1413);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
